moore_10001_gen: RTL and testbench
==================================

# moore_10001_gen

Serial Moore-style pattern transmitter that drives the bit sequence 1-0-0-0-1 onto a one-bit line, one bit per clock, for a requested number of repetitions. It is the sending end of the DAY 11 non-overlapping 10001 sequence detector: its `out` feeds the detector's `in` directly, at the same clock. It provides stimulus generation and loopback checking for the FSM exercises.

## Interface
Parameters:
- `PATTERN`, 5'b10001: bit pattern, transmitted MSB first.
- `PAT_LEN`, 5: pattern length in bits, 2..16.
- `GAP`, 1: idle cycles with `out`=0 between repetitions, 0..15.
- `CNT_W`, 4: width of the repetition count.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous and active-low. One clock; reset is synchronous and active-low.
- `start`  in  1  request a burst; sampled only in IDLE.
- `count`  in  CNT_W  number of repetitions; captured on accepted `start`; 0 is treated as 1.
- `stop`  in  1  abort the current burst.
- `out`  out  1  serial pattern bit.
- `valid`  out  1  high while `out` carries a pattern bit. Low in the gap.
- `frame`  out  1  high on the first bit of each repetition.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final bit of a completed burst.
- `chk_err`  out  1  present only with `MOORE_GEN_CHK_EN`.

## Operation
- **Moore machine.** All outputs are registered decodes of the state and index. No input reaches an output combinationally.
- **States:** IDLE, SHIFT, GAP, DONE.
- **IDLE**
  - Outputs: all outputs 0.
  - On `start`=1: capture `count` as `reps_left` (count 0 becomes 1), set `idx`=0, go to SHIFT.
- **SHIFT**
  - Outputs: `out`=PATTERN[PAT_LEN-1-idx], `valid`=1, `frame`=(idx==0). `idx` increments every cycle.
  - At idx==PAT_LEN-1:
    - If `reps_left`==1, go to DONE.
    - Otherwise decrement `reps_left`, then go to GAP if GAP>0, else to SHIFT with idx=0.
- **GAP**
  - Outputs: `out`=0, `valid`=0.
  - Hold for exactly GAP cycles (gap counter), then go to SHIFT with idx=0.
- **DONE**
  - Outputs: `done`=1, `out`=0, `busy`=1.
  - Next state: IDLE, unconditionally.
- **Start handling.**
  - `start` is ignored in SHIFT, GAP and DONE. No queuing.
  - `start` asserted in the IDLE cycle that follows DONE is accepted.
- **Stop handling.**
  - `stop`=1 in SHIFT or GAP sends the machine to IDLE at that edge. No `done` pulse.
  - `stop` takes priority over any other transition.
  - `stop` in IDLE or DONE has no effect.
- **Reset.** `rst`=0 at any edge, including mid-burst, forces IDLE. Reset values: `out`=0, `valid`=0, `frame`=0, `busy`=0, `done`=0, `chk_err`=0, all counters 0.
- **Widths.**
  - `idx` is $clog2(PAT_LEN) bits.
  - Gap counter is 4 bits.
  - `reps_left` is CNT_W bits and never wraps, because the burst ends at 1.

## Timing
- Latency: `start` sampled at edge N gives the first bit on `out` during cycle N+1.
- Bit period: one clock.
- Burst length in cycles: R·PAT_LEN + (R-1)·GAP, followed by one DONE cycle. R is the effective count.
- `busy` rises at edge N and falls one cycle after `done`.
- Earliest restart: a new `start` is accepted at the edge that leaves DONE+1, i.e. in IDLE. Minimum idle between bursts is one cycle.

## Configuration
- **Macro:** `MOORE_GEN_CHK_EN`.
- **Defined:**
  - An internal non-overlapping 10001 Moore detector samples `out` and counts matches.
  - The count is cleared on accepted `start`.
  - In DONE, `chk_err` is set if match count ≠ R. It is sticky until reset or the next accepted `start`.
  - An aborted burst never sets `chk_err`.
- **Undefined:** the detector and its counter are not built, and the `chk_err` port is absent.

## Structure
- **Shared package `moore_seq_pkg`:**
  - State enum (IDLE, SHIFT, GAP, DONE).
  - Default PATTERN/PAT_LEN constants.
  - Gap counter width constant, 4.
- **Sub-module `moore_seq_chk`** (checker detector, instantiated only under the macro):
  - Inputs: `clk`, `rst`, `in`, `clr`.
  - Output: `match_cnt`, CNT_W+1 bits.

## Test plan
1. Reset for 2 cycles, then `start`=1, `count`=1 for one cycle. Required: `out`=1,0,0,0,1 on cycles N+1..N+5, `frame` high at N+1 only, `done` at N+6, `busy` low at N+7.
2. `count`=3, GAP=1. Required: `out`=10001 0 10001 0 10001, `valid` low on the two gap cycles, 17 busy cycles before `done`.
3. `count`=0. Required: behaves exactly as `count`=1, a single pattern and one `done`.
4. `stop`=1 on the 3rd bit of repetition 2 of a `count`=4 burst. Required: IDLE next cycle, `out`=0, no `done`. A `start` pulsed during the burst is ignored.
5. `rst`=0 mid-SHIFT of a `count`=2 burst. Required: all outputs 0 at the next edge, and a new `start` after release begins a fresh burst.
6. With `MOORE_GEN_CHK_EN` defined, GAP=0, `count`=5. Required: `out` is 25 bits of back-to-back 10001 and `chk_err`=0. Forcing the checker input to 0 mid-burst gives `chk_err`=1 from DONE onward.

Source files
------------

// File: rtl/moore_seq_pkg.sv
// Shared types and defaults for the 10001 Moore pattern generator and its loopback checker.
package moore_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   // Detector states name the prefix of 10001 seen so far; DET_HIT is the Moore match state.
   typedef enum logic [2:0] {
      DET_NONE  = 3'd0,
      DET_1     = 3'd1,
      DET_10    = 3'd2,
      DET_100   = 3'd3,
      DET_1000  = 3'd4,
      DET_HIT   = 3'd5
   } det_state_e;

   localparam logic [4:0] DEF_PATTERN = 5'b10001;
   localparam int         DEF_PAT_LEN = 5;
   localparam int         GAP_CNT_W   = 4;

endpackage

// File: rtl/moore_seq_chk.sv
// Non-overlapping 10001 Moore detector that counts matches on the looped-back serial line.
module moore_seq_chk
   import moore_seq_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             clr,
   output logic [CNT_W:0]   match_cnt
);

   det_state_e det_state;
   det_state_e det_nxt;

   always_comb begin
      det_nxt = DET_NONE;
      unique case (det_state)
         DET_NONE: det_nxt = in ? DET_1    : DET_NONE;
         DET_1:    det_nxt = in ? DET_1    : DET_10;
         DET_10:   det_nxt = in ? DET_1    : DET_100;
         DET_100:  det_nxt = in ? DET_1    : DET_1000;
         DET_1000: det_nxt = in ? DET_HIT  : DET_NONE;
         DET_HIT:  det_nxt = in ? DET_1    : DET_NONE;
         default:  det_nxt = DET_NONE;
      endcase
   end

   // Count on entry to the hit state so the total is settled during the generator's DONE cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         det_state <= DET_NONE;
         match_cnt <= '0;
      end else if (clr) begin
         det_state <= DET_NONE;
         match_cnt <= '0;
      end else begin
         det_state <= det_nxt;
         if (det_nxt == DET_HIT && match_cnt != '1)
            match_cnt <= match_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/moore_10001_gen.sv
// Serial Moore transmitter repeating PATTERN MSB-first for a requested count of repetitions.
// Optional loopback checker and chk_err port are built when MOORE_GEN_CHK_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | waiting for start, all outputs low
// ST_SHIFT | driving PATTERN[PAT_LEN-1-idx], idx walks 0..PAT_LEN-1
// ST_GAP   | GAP idle cycles between repetitions, out/valid low
// ST_DONE  | one-cycle done pulse, then back to idle
module moore_10001_gen
   import moore_seq_pkg::*;
#(
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
   parameter int                 GAP     = 1,
   parameter int                 CNT_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             stop,
   output logic             out,
   output logic             valid,
   output logic             frame,
   output logic             busy,
   output logic             done
`ifdef MOORE_GEN_CHK_EN
   ,
   output logic             chk_err
`endif
);

   localparam int IDX_W = $clog2(PAT_LEN);
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(PAT_LEN - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

   seq_state_e           state, state_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [CNT_W-1:0]     reps_left, reps_nxt;
   logic [GAP_CNT_W-1:0] gap_cnt, gap_nxt;
   logic                 start_acc;

   logic out_nxt, valid_nxt, frame_nxt, busy_nxt, done_nxt;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      reps_nxt  = reps_left;
      gap_nxt   = gap_cnt;
      start_acc = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               reps_nxt  = (count == '0) ? CNT_W'(1) : count;
               idx_nxt   = '0;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (stop) begin
               state_nxt = ST_IDLE;
               idx_nxt   = '0;
               reps_nxt  = '0;
               gap_nxt   = '0;
            end else if (idx == IDX_LAST) begin
               idx_nxt = '0;
               if (reps_left == CNT_W'(1)) begin
                  state_nxt = ST_DONE;
               end else begin
                  reps_nxt = reps_left - 1'b1;
                  if (GAP > 0) begin
                     state_nxt = ST_GAP;
                     gap_nxt   = GAP_LOAD;
                  end else begin
                     state_nxt = ST_SHIFT;
                  end
               end
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         ST_GAP: begin
            if (stop) begin
               state_nxt = ST_IDLE;
               idx_nxt   = '0;
               reps_nxt  = '0;
               gap_nxt   = '0;
            end else if (gap_cnt == '0) begin
               state_nxt = ST_SHIFT;
               idx_nxt   = '0;
            end else begin
               gap_nxt = gap_cnt - 1'b1;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            reps_nxt  = '0;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_comb begin
      out_nxt   = 1'b0;
      valid_nxt = 1'b0;
      frame_nxt = 1'b0;
      busy_nxt  = (state_nxt != ST_IDLE);
      done_nxt  = (state_nxt == ST_DONE);
      if (state_nxt == ST_SHIFT) begin
         out_nxt   = PATTERN[IDX_LAST - idx_nxt];
         valid_nxt = 1'b1;
         frame_nxt = (idx_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         idx       <= '0;
         reps_left <= '0;
         gap_cnt   <= '0;
         out       <= 1'b0;
         valid     <= 1'b0;
         frame     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         idx       <= idx_nxt;
         reps_left <= reps_nxt;
         gap_cnt   <= gap_nxt;
         out       <= out_nxt;
         valid     <= valid_nxt;
         frame     <= frame_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

`ifdef MOORE_GEN_CHK_EN
   logic             chk_in;
   logic [CNT_W:0]   match_cnt;
   logic [CNT_W-1:0] reps_tot;

   assign chk_in = out;

   moore_seq_chk #(
      .CNT_W (CNT_W)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .in        (chk_in),
      .clr       (start_acc),
      .match_cnt (match_cnt)
   );

   // Only a burst that reaches DONE is judged; an aborted burst leaves chk_err alone.
   always_ff @(posedge clk) begin
      if (!rst) begin
         reps_tot <= '0;
         chk_err  <= 1'b0;
      end else if (start_acc) begin
         reps_tot <= reps_nxt;
         chk_err  <= 1'b0;
      end else if (state == ST_DONE && match_cnt != {1'b0, reps_tot}) begin
         chk_err  <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_moore_10001_gen.sv
// Randomized bench for moore_10001_gen: two instances (GAP=1 and GAP=0) against a queue-based model.
module tb_moore_10001_gen;

   localparam int CNT_W = 4;
   localparam int PLEN  = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [CNT_W-1:0] count = '0;

   logic o_s[2], v_s[2], f_s[2], b_s[2], d_s[2];
`ifdef MOORE_GEN_CHK_EN
   logic c_s[2];
`endif

   always #5 clk = ~clk;

   moore_10001_gen #(.GAP(0), .CNT_W(CNT_W)) dut0 (
      .clk(clk), .rst(rst), .start(start), .count(count), .stop(stop),
      .out(o_s[0]), .valid(v_s[0]), .frame(f_s[0]), .busy(b_s[0]), .done(d_s[0])
`ifdef MOORE_GEN_CHK_EN
      , .chk_err(c_s[0])
`endif
   );

   moore_10001_gen #(.GAP(1), .CNT_W(CNT_W)) dut1 (
      .clk(clk), .rst(rst), .start(start), .count(count), .stop(stop),
      .out(o_s[1]), .valid(v_s[1]), .frame(f_s[1]), .busy(b_s[1]), .done(d_s[1])
`ifdef MOORE_GEN_CHK_EN
      , .chk_err(c_s[1])
`endif
   );

   // Model: each accepted start expands into the full list of per-cycle output vectors.
   typedef struct packed {
      logic o;
      logic v;
      logic f;
      logic d;
   } ent_t;

   ent_t       mq[2][$];
   logic       chk_exp[2];
   logic       forced[2];
   logic [4:0] pat_bits = 5'b10001;
   int         vectors = 0;
   int         errors = 0;
   int         cyc = 0;

   task automatic build(input int k);
      int r;
      ent_t e;
      r = (count == 0) ? 1 : int'(count);
      for (int rep = 0; rep < r; rep++) begin
         for (int b = 0; b < PLEN; b++) begin
            e.o = pat_bits[PLEN-1-b];
            e.v = 1'b1;
            e.f = (b == 0);
            e.d = 1'b0;
            mq[k].push_back(e);
         end
         if (rep < r - 1) begin
            for (int g = 0; g < k; g++) begin
               e = '0;
               mq[k].push_back(e);
            end
         end
      end
      e = '0;
      e.d = 1'b1;
      mq[k].push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            mq[k].delete();
            chk_exp[k] = 1'b0;
            forced[k]  = 1'b0;
         end else if (mq[k].size() > 0) begin
            if (stop && !mq[k][0].d) begin
               mq[k].delete();
            end else begin
               if (mq[k][0].d && forced[k]) chk_exp[k] = 1'b1;
               void'(mq[k].pop_front());
            end
         end else if (start) begin
            build(k);
            chk_exp[k] = 1'b0;
            forced[k]  = 1'b0;
         end
      end
      #1;
   endtask

   function automatic logic [4:0] expv(input int k);
      if (mq[k].size() == 0) return 5'b0;
      return {mq[k][0].o, mq[k][0].v, mq[k][0].f, 1'b1, mq[k][0].d};
   endfunction

   function automatic logic [4:0] obsv(input int k);
      return {o_s[k], v_s[k], f_s[k], b_s[k], d_s[k]};
   endfunction

   task automatic test_reset();
      rst = 1'b0; start = 1'b1; count = 4'd3;
      for (int i = 0; i < 2; i++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obsv(k) !== 5'b0) begin
               errors++;
               $display("FAIL reset dut%0d cyc %0d: {out,valid,frame,busy,done} got %b want 00000", k, cyc, obsv(k));
            end
`ifdef MOORE_GEN_CHK_EN
            vectors++;
            if (c_s[k] !== 1'b0) begin
               errors++;
               $display("FAIL reset_chk dut%0d: chk_err got %b want 0", k, c_s[k]);
            end
`endif
         end
      end
      rst = 1'b1; start = 1'b0;
      step();
   endtask

   // Pulse start with the given count, then follow the burst out to idle.
   task automatic test_burst(input string name, input logic [CNT_W-1:0] cnt);
      int n;
      count = cnt; start = 1'b1;
      step();
      start = 1'b0;
      n = 0;
      while ((mq[0].size() > 0 || mq[1].size() > 0 || n == 0) && n < 200) begin
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obsv(k) !== expv(k)) begin
               errors++;
               $display("FAIL %s dut%0d cyc %0d: {out,valid,frame,busy,done} got %b want %b", name, k, cyc, obsv(k), expv(k));
            end
         end
         step();
         n++;
      end
      if (n >= 200) begin
         errors++;
         $display("FAIL %s: burst did not end within 200 cycles", name);
      end
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (obsv(k) !== 5'b0) begin
            errors++;
            $display("FAIL %s_idle dut%0d: got %b want 00000", name, k, obsv(k));
         end
      end
   endtask

   task automatic test_stop();
      count = 4'd4; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obsv(k) !== expv(k)) begin
               errors++;
               $display("FAIL stop dut%0d cyc %0d: got %b want %b", k, cyc, obsv(k), expv(k));
            end
         end
         start = (i == 3);
         stop  = (i == 9);
         step();
      end
      stop = 1'b0;
      vectors++;
      if (obsv(1) !== 5'b0) begin
         errors++;
         $display("FAIL stop_idle dut1: got %b want 00000", obsv(1));
      end
   endtask

   task automatic test_reset_mid();
      count = 4'd2; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (obsv(k) !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid dut%0d: got %b want 00000", k, obsv(k));
         end
      end
      rst = 1'b1;
      test_burst("after_reset", 4'd2);
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         start = ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, 19) == 0);
         count = CNT_W'($urandom_range(0, 15));
         rst   = ($urandom_range(0, 149) != 0);
         step();
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obsv(k) !== expv(k)) begin
               errors++;
               $display("FAIL random dut%0d cyc %0d: got %b want %b", k, cyc, obsv(k), expv(k));
            end
`ifdef MOORE_GEN_CHK_EN
            vectors++;
            if (c_s[k] !== chk_exp[k]) begin
               errors++;
               $display("FAIL random_chk dut%0d cyc %0d: chk_err got %b want %b", k, cyc, c_s[k], chk_exp[k]);
            end
`endif
         end
      end
      start = 1'b0; stop = 1'b0; rst = 1'b1;
      for (int i = 0; i < 120; i++) step();
   endtask

`ifdef MOORE_GEN_CHK_EN
   task automatic test_chk(input string name, input logic do_force);
      count = 4'd5; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 28; i++) begin
         if (do_force && i == 6) begin
            force dut0.chk_in = 1'b0;
            forced[0] = 1'b1;
         end
         if (do_force && i == 11) release dut0.chk_in;
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (obsv(k) !== expv(k) || c_s[k] !== chk_exp[k]) begin
               errors++;
               $display("FAIL %s dut%0d cyc %0d: outs got %b want %b, chk_err got %b want %b",
                        name, k, cyc, obsv(k), expv(k), c_s[k], chk_exp[k]);
            end
         end
         step();
      end
      for (int i = 0; i < 12; i++) step();
      vectors++;
      if (c_s[0] !== do_force) begin
         errors++;
         $display("FAIL %s_final dut0: chk_err got %b want %b", name, c_s[0], do_force);
      end
   endtask
`endif

   initial begin
      for (int k = 0; k < 2; k++) begin
         chk_exp[k] = 1'b0;
         forced[k]  = 1'b0;
      end
      test_reset();
      test_burst("single", 4'd1);
      test_burst("gap3", 4'd3);
      test_burst("count0", 4'd0);
      test_burst("max", 4'd15);
      test_stop();
      step();
      test_reset_mid();
      test_burst("back_to_back", 4'd2);
`ifdef MOORE_GEN_CHK_EN
      test_chk("chk_clean", 1'b0);
      test_chk("chk_forced", 1'b1);
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
